// File: rtl/fft_reorder_if.sv
// ============================================================================
// Module      : fft_reorder_if
// Description : Stream interface for the FFT bit-reversal reorder block.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fft_reorder_if #(
  parameter int WIDTH = 9
);
  logic                    in_valid;
  logic                    in_sof;
  logic signed [WIDTH-1:0] inUp_re;
  logic signed [WIDTH-1:0] inUp_im;
  logic signed [WIDTH-1:0] inL_re;
  logic signed [WIDTH-1:0] inL_im;
  logic                    out_valid;
  logic                    out_sof;
  logic [3:0]              out_k;
  logic signed [WIDTH-1:0] outA_re;
  logic signed [WIDTH-1:0] outA_im;
  logic signed [WIDTH-1:0] outB_re;
  logic signed [WIDTH-1:0] outB_im;
  logic                    err_sof;

  modport master (
    output in_valid, in_sof, inUp_re, inUp_im, inL_re, inL_im,
    input  out_valid, out_sof, out_k, outA_re, outA_im, outB_re, outB_im, err_sof
  );

  modport slave (
    input  in_valid, in_sof, inUp_re, inUp_im, inL_re, inL_im,
    output out_valid, out_sof, out_k, outA_re, outA_im, outB_re, outB_im, err_sof
  );
endinterface

`default_nettype wire

// File: rtl/fft_reorder.sv
// ============================================================================
// Module      : fft_reorder
// Description : Bit-reversed to natural order reorder for a 32-point FFT,
//               ping-pong banks, two bins per beat.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fft_reorder #(
  parameter int WIDTH = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  fft_reorder_if.slave bus
);

  localparam int ENTRY_W = 2 * WIDTH;

  // Both banks share one array; the top address bit is the bank select.
  logic [ENTRY_W-1:0] mem [0:63];

  logic [3:0] c;
  logic [3:0] k;
  logic       wr_bank;
  logic       rd_bank;
  logic       rd_active;

  logic [3:0]         c_eff;
  logic [4:0]         addr_up;
  logic [4:0]         addr_lo;
  logic               frame_done;
  logic [ENTRY_W-1:0] ent_a;
  logic [ENTRY_W-1:0] ent_b;

  always_comb begin
    c_eff      = bus.in_sof ? 4'd0 : c;
    // bitrev5 of 2c: bit 0 of 2c is zero, so the reversed MSB is always zero.
    addr_up    = {1'b0, c_eff[0], c_eff[1], c_eff[2], c_eff[3]};
    addr_lo    = addr_up | 5'd16;
    frame_done = bus.in_valid && (c_eff == 4'd15);
    ent_a      = mem[{rd_bank, k, 1'b0}];
    ent_b      = mem[{rd_bank, k, 1'b1}];
  end

  always_ff @(posedge clk) begin
    if (bus.in_valid) begin
      mem[{wr_bank, addr_up}] <= {bus.inUp_re, bus.inUp_im};
      mem[{wr_bank, addr_lo}] <= {bus.inL_re, bus.inL_im};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c             <= 4'd0;
      k             <= 4'd0;
      wr_bank       <= 1'b0;
      rd_bank       <= 1'b0;
      rd_active     <= 1'b0;
      bus.err_sof   <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_sof   <= 1'b0;
      bus.out_k     <= 4'd0;
      bus.outA_re   <= '0;
      bus.outA_im   <= '0;
      bus.outB_re   <= '0;
      bus.outB_im   <= '0;
    end else begin
      // A restart mid-frame keeps wr_bank, so the partial frame is overwritten.
      bus.err_sof <= bus.in_valid && bus.in_sof && (c != 4'd0);

      if (bus.in_valid) begin
        c <= c_eff + 4'd1;
        if (frame_done) begin
          wr_bank <= ~wr_bank;
        end
      end

      // A new frame can only complete on the last beat of the previous readout.
      if (frame_done) begin
        rd_active <= 1'b1;
        rd_bank   <= wr_bank;
        k         <= 4'd0;
      end else if (rd_active) begin
        k <= k + 4'd1;
        if (k == 4'd15) begin
          rd_active <= 1'b0;
        end
      end

      bus.out_valid <= rd_active;
      bus.out_sof   <= rd_active && (k == 4'd0);
      bus.out_k     <= rd_active ? k : 4'd0;
      bus.outA_re   <= rd_active ? ent_a[ENTRY_W-1:WIDTH] : '0;
      bus.outA_im   <= rd_active ? ent_a[WIDTH-1:0]       : '0;
      bus.outB_re   <= rd_active ? ent_b[ENTRY_W-1:WIDTH] : '0;
      bus.outB_im   <= rd_active ? ent_b[WIDTH-1:0]       : '0;
    end
  end

endmodule

`default_nettype wire
